// File: rtl/thread_scheduler.sv
// Fine-grained multithread issue scheduler: each cycle selects one hardware thread,
// either by fixed barrel rotation or by round-robin that skips ineligible threads.
module thread_scheduler #(
    parameter int NUM_THREADS       = 4,
    parameter int INSTMEM_LOG2_DEEP = 8,
    parameter int SKIP_MODE         = 0,
    parameter int TID_W             = $clog2(NUM_THREADS)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NUM_THREADS*INSTMEM_LOG2_DEEP-1:0] pc_i,
    input  logic [NUM_THREADS-1:0]                   thread_en_i,
    input  logic [NUM_THREADS-1:0]                   thread_rdy_i,
    input  logic                                     hold_i,
    output logic [TID_W-1:0]                         thread_id_o,
    output logic [INSTMEM_LOG2_DEEP-1:0]             pc_select_o,
    output logic                                     valid_o
);

    localparam int               W        = INSTMEM_LOG2_DEEP;
    localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);
    localparam logic [TID_W:0]   N_EXT    = (TID_W + 1)'(NUM_THREADS);

    logic [TID_W-1:0]       cur_q, cur_d;
    logic                   vld_q, vld_d;
    logic [NUM_THREADS-1:0] elig;
    logic [W-1:0]           pc_arr [NUM_THREADS];

    assign elig = thread_en_i & thread_rdy_i;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_pc
        assign pc_arr[t] = pc_i[t*W +: W];
    end

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        logic [TID_W:0] sum;
        logic           found;
        cur_d = cur_q;
        vld_d = vld_q;
        sum   = '0;
        found = 1'b0;
        if (!hold_i) begin
            if (SKIP_MODE == 0) begin
                cur_d = (cur_q == LAST_TID) ? '0 : cur_q + TID_W'(1);
                vld_d = elig[cur_d];
            end else begin
                vld_d = 1'b0;
                // Candidates cur+1 .. cur+N; the extra bit keeps the sum from wrapping
                // before the modulo-N reduction, which matters for non-power-of-2 N.
                for (int k = 1; k <= NUM_THREADS; k++) begin
                    sum = {1'b0, cur_q} + (TID_W + 1)'(k);
                    if (sum >= N_EXT) begin
                        sum = sum - N_EXT;
                    end
                    if (!found && elig[sum[TID_W-1:0]]) begin
                        found = 1'b1;
                        cur_d = sum[TID_W-1:0];
                        vld_d = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q <= LAST_TID;
            vld_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            vld_q <= vld_d;
        end
    end

    assign thread_id_o = cur_q;
    assign pc_select_o = pc_arr[cur_q];
    assign valid_o     = vld_q & thread_en_i[cur_q];

endmodule
